pulse_edge_monitor: RTL

- Synthesizable, in-design counterpart to the team's bench-side `$rose`/`$fell` sampled-value assertions.
- Samples a single-bit input on every clock edge and emits registered rose, fell and stable pulses.
- Measures high-pulse width between a rise and the following fall, and flags pulses that are too short or too long.
- Sits beside any control strobe whose edges the team currently checks only in simulation, so the same checks survive into silicon and FPGA.

---
 rtl/pulse_edge_monitor_if.sv | 35 +++
 rtl/pulse_edge_monitor.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/pulse_edge_monitor_if.sv
// Bundle of the monitored strobe, its controls and every monitor result.
// master: the side driving the strobe (controller or bench).
// slave: the monitor itself.
interface pulse_edge_monitor_if #(
    parameter int MAX_W = 8,
    parameter int CW    = 8
);
    localparam int WW = $clog2(MAX_W + 2);

    logic          a;
    logic          en_i;
    logic          clr_i;
    logic          rose_o;
    logic          fell_o;
    logic          stable_o;
    logic          pass_o;
    logic          err_short_o;
    logic          err_long_o;
    logic          err_o;
    logic [WW-1:0] width_o;
    logic [CW-1:0] rose_cnt_o;
    logic [CW-1:0] fell_cnt_o;

    modport master (
        output a, en_i, clr_i,
        input  rose_o, fell_o, stable_o, pass_o, err_short_o, err_long_o,
               err_o, width_o, rose_cnt_o, fell_cnt_o
    );

    modport slave (
        input  a, en_i, clr_i,
        output rose_o, fell_o, stable_o, pass_o, err_short_o, err_long_o,
               err_o, width_o, rose_cnt_o, fell_cnt_o
    );
endinterface

// File: rtl/pulse_edge_monitor.sv
// Edge / pulse-width monitor for a single-bit control strobe.
// Emits registered rose/fell/stable pulses, saturating edge counters and
// a high-width check against MIN_W..MAX_W with a sticky error flag.
// Optional macro PULSE_EDGE_MONITOR_SYNC_EN inserts a 2-flop synchronizer
// in front of the sampler for strobes from another clock domain.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no measurement running, waiting for a rise with en_i=1
// MEASURE | counting high samples of the current pulse in cnt
// OVERRUN | pulse already exceeded MAX_W, waiting for the fall
module pulse_edge_monitor #(
    parameter int MIN_W = 2,
    parameter int MAX_W = 8,
    parameter int CW    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pulse_edge_monitor_if.slave   bus
);
    localparam int WW = $clog2(MAX_W + 2);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        OVERRUN = 2'd2
    } state_t;

    logic          a_s;
    logic          a_q;
    logic          rise;
    logic          fall;
    state_t        state;
    state_t        state_nx;
    logic [WW-1:0] cnt;
    logic [WW-1:0] cnt_nx;
    logic          pass_nx;
    logic          short_nx;
    logic          long_nx;
    logic          width_ld;
    logic [CW-1:0] rose_base;
    logic [CW-1:0] fell_base;

`ifdef PULSE_EDGE_MONITOR_SYNC_EN
    logic sync1;
    logic sync2;

    // Two-flop synchronizer; adds exactly two cycles ahead of the sampler.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= bus.a;
            sync2 <= sync1;
        end
    end

    assign a_s = sync2;
`else
    assign a_s = bus.a;
`endif

    assign rise = a_s & ~a_q;
    assign fall = ~a_s & a_q;

    // A clear coinciding with an edge leaves the counter at 1, hence clear first.
    assign rose_base = bus.clr_i ? '0 : bus.rose_cnt_o;
    assign fell_base = bus.clr_i ? '0 : bus.fell_cnt_o;

    // Next-state and result pulses for the width measurement.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        pass_nx  = 1'b0;
        short_nx = 1'b0;
        long_nx  = 1'b0;
        width_ld = 1'b0;
        if (!bus.en_i) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (rise) begin
                        state_nx = MEASURE;
                        cnt_nx   = WW'(1);
                    end
                end
                MEASURE: begin
                    if (a_s) begin
                        if (cnt == WW'(MAX_W)) begin
                            long_nx  = 1'b1;
                            state_nx = OVERRUN;
                        end else begin
                            cnt_nx = cnt + 1'b1;
                        end
                    end else begin
                        width_ld = 1'b1;
                        if (cnt < WW'(MIN_W)) begin
                            short_nx = 1'b1;
                        end else begin
                            pass_nx = 1'b1;
                        end
                        state_nx = IDLE;
                    end
                end
                OVERRUN: begin
                    if (!a_s) begin
                        state_nx = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // State register and all registered outputs; reset drops any measurement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            cnt             <= '0;
            a_q             <= 1'b0;
            bus.rose_o      <= 1'b0;
            bus.fell_o      <= 1'b0;
            bus.stable_o    <= 1'b1;
            bus.pass_o      <= 1'b0;
            bus.err_short_o <= 1'b0;
            bus.err_long_o  <= 1'b0;
            bus.err_o       <= 1'b0;
            bus.width_o     <= '0;
            bus.rose_cnt_o  <= '0;
            bus.fell_cnt_o  <= '0;
        end else begin
            state           <= state_nx;
            cnt             <= cnt_nx;
            a_q             <= a_s;
            bus.rose_o      <= rise;
            bus.fell_o      <= fall;
            bus.stable_o    <= (a_s == a_q);
            bus.pass_o      <= pass_nx;
            bus.err_short_o <= short_nx;
            bus.err_long_o  <= long_nx;
            bus.err_o       <= (bus.err_o & ~bus.clr_i) | short_nx | long_nx;
            if (width_ld) begin
                bus.width_o <= cnt;
            end
            bus.rose_cnt_o  <= (rise && rose_base != '1) ? rose_base + 1'b1 : rose_base;
            bus.fell_cnt_o  <= (fall && fell_base != '1) ? fell_base + 1'b1 : fell_base;
        end
    end
endmodule
